// File: rtl/muldiv_if.sv
// Handshake and result bundle between the pipeline control and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funcw;
  logic [WIDTH-1:0] input1w;
  logic [WIDTH-1:0] input2w;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funcw, input1w, input2w,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, funcw, input1w, input2w,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers.
// Optional MULDIV_DIV0_FAST_EN: divide-by-zero bypasses CALC and goes straight to FIX.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic     clk,
    input logic     rst_b,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_hi, p_lo, b_q, a_raw;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic is_div, neg_a, neg_b, div0;

    logic legal, accept;
    logic in_div, in_signed, in_div0, in_neg_a, in_neg_b;
    logic [WIDTH-1:0] mag1, mag2;

    logic [WIDTH:0] sum, rem_sh, diff;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0] quo, rem, hi_n, lo_n;

    // Legal codes are 0110xx; bit1 selects divide, bit0 selects unsigned.
    assign legal     = (bus.funcw[5:2] == 4'b0110);
    assign in_div    = bus.funcw[1];
    assign in_signed = ~bus.funcw[0];
    assign in_neg_a  = in_signed & bus.input1w[WIDTH-1];
    assign in_neg_b  = in_signed & bus.input2w[WIDTH-1];
    assign in_div0   = in_div & (bus.input2w == '0);
    assign mag1      = in_neg_a ? -bus.input1w : bus.input1w;
    assign mag2      = in_neg_b ? -bus.input2w : bus.input2w;

    assign accept = bus.start & legal & ((state == IDLE) | (state == DONE));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
`ifdef MULDIV_DIV0_FAST_EN
                    state_n = in_div0 ? FIX : CALC;
`else
                    state_n = CALC;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            CALC:    if (cnt == LAST) state_n = FIX;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // One iteration: p_hi is the running partial product or remainder,
    // p_lo shifts out multiplier bits / dividend bits and shifts in quotient bits.
    always_comb begin
        sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_q} : '0);
        rem_sh  = {p_hi, p_lo[WIDTH-1]};
        diff    = rem_sh - {1'b0, b_q};
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], p_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                step_hi = diff[WIDTH-1:0];
                step_lo = {p_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {p_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod     = {p_hi, p_lo};
        prod_neg = -prod;
        quo      = (neg_a ^ neg_b) ? -p_lo : p_lo;
        rem      = neg_a ? -p_hi : p_hi;
        hi_n     = prod[2*WIDTH-1:WIDTH];
        lo_n     = prod[WIDTH-1:0];
        if (div0) begin
            hi_n = a_raw;
            lo_n = '1;
        end else if (is_div) begin
            hi_n = rem;
            lo_n = quo;
        end else if (neg_a ^ neg_b) begin
            hi_n = prod_neg[2*WIDTH-1:WIDTH];
            lo_n = prod_neg[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state  <= IDLE;
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            b_q    <= '0;
            a_raw  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt    <= '0;
                p_hi   <= '0;
                p_lo   <= mag1;
                b_q    <= mag2;
                a_raw  <= bus.input1w;
                is_div <= in_div;
                neg_a  <= in_neg_a;
                neg_b  <= in_neg_b;
                div0   <= in_div0;
            end else if (state == CALC) begin
                cnt  <= cnt + CNT_W'(1);
                p_hi <= step_hi;
                p_lo <= step_lo;
            end
            if (state == FIX) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
            end
        end
    end

    assign bus.busy        = (state == CALC) | (state == FIX);
    assign bus.done        = (state == DONE);
    assign bus.div_by_zero = (state == DONE) & div0;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    int checks = 0;
    int passed = 0;
    logic [31:0] last_hi, last_lo;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Returns {div_by_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if ((f == F_DIV || f == F_DIVU) && b == 32'd0)
            return {1'b1, a, 32'hFFFFFFFF};
        case (f)
            F_MULT: begin
                sp = sa * sb;
                return {1'b0, sp[63:0]};
            end
            F_MULTU: begin
                up = ua * ub;
                return {1'b0, up[63:0]};
            end
            F_DIV: begin
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic int exp_lat(logic [5:0] f, logic [31:0] b);
`ifdef MULDIV_DIV0_FAST_EN
        if ((f == F_DIV || f == F_DIVU) && b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Present a request for one edge (E0); returns at E0+#1.
    task automatic start_op(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        bus.start   = 1'b1;
        bus.funcw   = f;
        bus.input1w = a;
        bus.input2w = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ok  = 1'b1;
                lat = i;
            end
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
        checks++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); else passed++;
        checks++; if (bus.hi !== 32'd0) $display("FAIL reset_hi got %h want 0", bus.hi); else passed++;
        checks++; if (bus.lo !== 32'd0) $display("FAIL reset_lo got %h want 0", bus.lo); else passed++;
        last_hi = 32'd0;
        last_lo = 32'd0;
    endtask

    task automatic test_directed;
        logic [5:0]  tf[7]  = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV, F_DIV, F_DIVU};
        logic [31:0] ta[7]  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100,
                                32'h80000000, 32'h12345678, 32'd5};
        logic [31:0] tb[7]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd7,
                                32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] thi[7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2,
                                32'd0, 32'h12345678, 32'd5};
        logic [31:0] tlo[7] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'd14,
                                32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic        tdz[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        bit ok;
        for (int i = 0; i < 7; i++) begin
            start_op(tf[i], ta[i], tb[i]);
            wait_done(lat, ok);
            checks++;
            if (!ok || lat != exp_lat(tf[i], tb[i]))
                $display("FAIL dir%0d_latency got %0d (seen=%0b) want %0d", i, lat, ok, exp_lat(tf[i], tb[i]));
            else passed++;
            checks++; if (bus.hi !== thi[i]) $display("FAIL dir%0d_hi got %h want %h", i, bus.hi, thi[i]); else passed++;
            checks++; if (bus.lo !== tlo[i]) $display("FAIL dir%0d_lo got %h want %h", i, bus.lo, tlo[i]); else passed++;
            checks++; if (bus.div_by_zero !== tdz[i]) $display("FAIL dir%0d_dbz got %b want %b", i, bus.div_by_zero, tdz[i]); else passed++;
            last_hi = thi[i];
            last_lo = tlo[i];
        end
    endtask

    task automatic test_random;
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [64:0] exp;
        int lat;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            f = 6'b011000 | 6'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            exp = model(f, a, b);
            start_op(f, a, b);
            wait_done(lat, ok);
            checks++;
            if (!ok || lat != exp_lat(f, b))
                $display("FAIL rnd%0d_latency f=%b got %0d want %0d", i, f, lat, exp_lat(f, b));
            else passed++;
            checks++;
            if ({bus.div_by_zero, bus.hi, bus.lo} !== exp)
                $display("FAIL rnd%0d_result f=%b a=%h b=%h got %b/%h/%h want %b/%h/%h", i, f, a, b,
                         bus.div_by_zero, bus.hi, bus.lo, exp[64], exp[63:32], exp[31:0]);
            else passed++;
            last_hi = exp[63:32];
            last_lo = exp[31:0];
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        bit ok;
        logic [64:0] exp;
        start_op(F_MULT, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL busy_mid got %b want 1", bus.busy); else passed++;
        checks++;
        if (bus.hi !== last_hi || bus.lo !== last_lo)
            $display("FAIL hold_during_busy got %h/%h want %h/%h", bus.hi, bus.lo, last_hi, last_lo);
        else passed++;
        repeat (4) @(posedge clk);
        #1;
        start_op(F_DIV, 32'd9, 32'd3);
        wait_done(lat, ok);
        checks++; if (!ok || lat != 23) $display("FAIL ignored_start_latency got %0d want 23", lat); else passed++;
        checks++; if (bus.hi !== 32'd0) $display("FAIL ignored_start_hi got %h want 0", bus.hi); else passed++;
        checks++; if (bus.lo !== 32'd15) $display("FAIL ignored_start_lo got %h want f", bus.lo); else passed++;
        start_op(F_DIVU, 32'd100, 32'd7);
        checks++; if (bus.busy !== 1'b1) $display("FAIL back_to_back_busy got %b want 1", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL back_to_back_done got %b want 0", bus.done); else passed++;
        wait_done(lat, ok);
        exp = model(F_DIVU, 32'd100, 32'd7);
        checks++; if (!ok || lat != 33) $display("FAIL back_to_back_latency got %0d want 33", lat); else passed++;
        checks++;
        if ({bus.hi, bus.lo} !== exp[63:0]) $display("FAIL back_to_back_result got %h/%h want %h", bus.hi, bus.lo, exp[63:0]);
        else passed++;
        last_hi = exp[63:32];
        last_lo = exp[31:0];
    endtask

    task automatic test_illegal;
        start_op(6'b100000, 32'd4, 32'd4);
        checks++; if (bus.busy !== 1'b0) $display("FAIL illegal_busy got %b want 0", bus.busy); else passed++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) $display("FAIL illegal_done got %b want 0", bus.done); else passed++;
        checks++;
        if (bus.hi !== last_hi || bus.lo !== last_lo)
            $display("FAIL illegal_hold got %h/%h want %h/%h", bus.hi, bus.lo, last_hi, last_lo);
        else passed++;
    endtask

    task automatic test_reset_midop;
        int seen = 0;
        start_op(F_MULTU, 32'hDEADBEEF, 32'h12345678);
        repeat (19) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL midreset_done got %b want 0", bus.done); else passed++;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0)
            $display("FAIL midreset_hilo got %h/%h want 0/0", bus.hi, bus.lo);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        checks++; if (seen != 0) $display("FAIL midreset_no_done got %0d pulses want 0", seen); else passed++;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.funcw   = 6'd0;
        bus.input1w = 32'd0;
        bus.input2w = 32'd0;
        test_reset;
        test_directed;
        test_random;
        test_busy_ignore;
        test_illegal;
        test_reset_midop;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
